uart_tx_sched: RTL and testbench

//   Shares the single UART transmitter between two byte sources: PS/2 keystroke echo and CPU MMIO writes.

---
 rtl/uart_tx_sched_pkg.sv | 24 ++
 rtl/uart_tx_sched_if.sv | 25 ++
 rtl/uart_tx_sched_byte_fifo.sv | 50 +++++
 rtl/uart_tx_sched.sv | 137 +++++++++++++
 tb/tb_uart_tx_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM states, grant encodings, grant arbitration.
// Combinational helpers only; nothing here holds state.
// No flow control of its own; it only encodes decisions made in uart_tx_sched.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic GNT_PS2 = 1'b0;
    localparam logic GNT_CPU = 1'b1;

    // Round-robin pick: with both sources pending, the one that did not win last time goes next.
    function automatic logic pick_grant(input logic ps2_ne, input logic cpu_ne, input logic last_grant);
        if (ps2_ne && cpu_ne) begin
            return (last_grant == GNT_CPU) ? GNT_PS2 : GNT_CPU;
        end
        return cpu_ne ? GNT_CPU : GNT_PS2;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer/consumer bundle around the UART scheduler: PS/2 and CPU byte strobes in, UART launch out.
// Pure wiring; no latency.
// Producers are never stalled; overflow shows up as cpu_full / ps2_drop only.
interface uart_tx_sched_if;
    logic       ps2_valid;
    logic [7:0] ps2_byte;
    logic       cpu_wen;
    logic [7:0] cpu_byte;
    logic       cpu_full;
    logic       ps2_drop;
    logic       uart_busy;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       sched_idle;

    modport master (
        output ps2_valid, ps2_byte, cpu_wen, cpu_byte, uart_busy,
        input  cpu_full, ps2_drop, uart_tx_en, uart_tx_data, sched_idle
    );

    modport slave (
        input  ps2_valid, ps2_byte, cpu_wen, cpu_byte, uart_busy,
        output cpu_full, ps2_drop, uart_tx_en, uart_tx_data, sched_idle
    );
endinterface

// File: rtl/uart_tx_sched_byte_fifo.sv
// Small byte FIFO with registered count; read data is the head entry, visible combinationally.
// Push lands one cycle later; pop advances the head at the clock edge.
// A push while full is discarded even if a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART between PS/2 echo and CPU bytes; optional stats via UART_SCHED_STATS_EN.
// Push into empty FIFO while idle -> uart_tx_en two cycles later; one byte per UART frame + 2 cycles.
// Producers never stall; paces on uart_busy, abandons the handshake if busy never rises.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH_LOG2   = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_sched_if.slave   bus
`ifdef UART_SCHED_STATS_EN
    ,
    output logic [15:0]      drop_count,
    output logic [15:0]      sent_count
`endif
);
    localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    state_t              state;
    state_t              state_nx;
    logic                last_grant;
    logic                grant;
    logic [TW-1:0]       timer;
    logic [7:0]          ps2_data;
    logic [7:0]          cpu_data;
    logic [7:0]          tx_data;
    logic                tx_en;
    logic                ps2_drop;
    logic                ps2_empty;
    logic                ps2_full;
    logic                cpu_empty;
    logic                cpu_full;
    logic                pop_ps2;
    logic                pop_cpu;
    logic                load;
    logic [DEPTH_LOG2:0] ps2_count;
    logic [DEPTH_LOG2:0] cpu_count;

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_ps2_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.ps2_valid),
        .push_data (bus.ps2_byte),
        .pop       (pop_ps2),
        .data      (ps2_data),
        .empty     (ps2_empty),
        .full      (ps2_full),
        .count     (ps2_count)
    );

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_cpu_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.cpu_wen),
        .push_data (bus.cpu_byte),
        .pop       (pop_cpu),
        .data      (cpu_data),
        .empty     (cpu_empty),
        .full      (cpu_full),
        .count     (cpu_count)
    );

    assign grant = pick_grant(!ps2_empty, !cpu_empty, last_grant);

    always_comb begin
        state_nx = state;
        pop_ps2  = 1'b0;
        pop_cpu  = 1'b0;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!ps2_empty || !cpu_empty) begin
                    load     = 1'b1;
                    pop_ps2  = (grant == GNT_PS2);
                    pop_cpu  = (grant == GNT_CPU);
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH:    state_nx = S_WAIT_BUSY;
            // A UART that never raises busy still releases the scheduler; the byte is treated as sent.
            S_WAIT_BUSY: begin
                if (bus.uart_busy)                       state_nx = S_WAIT_DONE;
                else if (timer == TW'(BUSY_TIMEOUT - 1)) state_nx = S_IDLE;
            end
            S_WAIT_DONE: if (!bus.uart_busy) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= GNT_CPU;
            tx_data    <= 8'h00;
            tx_en      <= 1'b0;
            timer      <= '0;
            ps2_drop   <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_en    <= (state_nx == S_LAUNCH);
            ps2_drop <= bus.ps2_valid && ps2_full;
            if (load) begin
                last_grant <= grant;
                tx_data    <= (grant == GNT_CPU) ? cpu_data : ps2_data;
            end
            if (state == S_LAUNCH)         timer <= '0;
            else if (state == S_WAIT_BUSY) timer <= timer + 1'b1;
        end
    end

    assign bus.uart_tx_en   = tx_en;
    assign bus.uart_tx_data = tx_data;
    assign bus.ps2_drop     = ps2_drop;
    assign bus.cpu_full     = cpu_full;
    assign bus.sched_idle   = (state == S_IDLE) && (ps2_count == '0) && (cpu_count == '0);

`ifdef UART_SCHED_STATS_EN
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    // Both sources can overflow in the same cycle, so the increment is 0..2 and saturates at 16'hFFFF.
    assign drop_inc = {1'b0, bus.ps2_valid && ps2_full} + {1'b0, bus.cpu_wen && cpu_full};
    assign drop_sum = {1'b0, drop_count} + {15'd0, drop_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= 16'd0;
            sent_count <= 16'd0;
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (state == S_LAUNCH) sent_count <= sent_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic against a queue-level reference model.
// The model keeps one queue per source and predicts launched bytes, drops and cpu_full each cycle.
module tb_uart_tx_sched;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset_n;
    uart_tx_sched_if bus();
`ifdef UART_SCHED_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] sent_count;
`endif

    uart_tx_sched #(.DEPTH_LOG2(2), .BUSY_TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef UART_SCHED_STATS_EN
        ,
        .drop_count (drop_count),
        .sent_count (sent_count)
`endif
    );

    always #10 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] ps2_q[$];
    logic [7:0] cpu_q[$];
    logic [7:0] launches[$];
    bit         last_cpu;
    bit         hold_mode;
    bit         hold_level;
    int         frame_left;
    int         frame_min = 3;
    int         frame_max = 8;
    int         drop_pulses;

    // One clock: the edge ends the cycle whose inputs are on the bus; outputs are checked at the negedge.
    task automatic tick();
        int         s_ps2;
        int         s_cpu;
        logic [7:0] exp;
        bit         exp_drop;
        @(posedge clk);
        @(negedge clk);
        s_ps2 = ps2_q.size();
        s_cpu = cpu_q.size();
        if (bus.uart_tx_en === 1'b1) begin
            n_cmp++;
            if (s_ps2 == 0 && s_cpu == 0) begin
                n_err++;
                $display("FAIL spurious_launch: launched %h, required no launch (both queues empty)", bus.uart_tx_data);
            end else begin
                if (s_cpu == 0 || (s_ps2 != 0 && last_cpu)) begin
                    exp = ps2_q.pop_front();
                    last_cpu = 1'b0;
                end else begin
                    exp = cpu_q.pop_front();
                    last_cpu = 1'b1;
                end
                if (bus.uart_tx_data !== exp) begin
                    n_err++;
                    $display("FAIL launch_data: got %h required %h", bus.uart_tx_data, exp);
                end
            end
            launches.push_back(bus.uart_tx_data);
            frame_left = $urandom_range(frame_max, frame_min);
        end
        exp_drop = 1'b0;
        if (bus.ps2_valid) begin
            if (s_ps2 < DEPTH) ps2_q.push_back(bus.ps2_byte);
            else exp_drop = 1'b1;
        end
        if (bus.cpu_wen && s_cpu < DEPTH) cpu_q.push_back(bus.cpu_byte);
        if (bus.ps2_drop === 1'b1) drop_pulses++;
        n_cmp++;
        if (bus.ps2_drop !== exp_drop) begin
            n_err++;
            $display("FAIL ps2_drop: got %b required %b", bus.ps2_drop, exp_drop);
        end
        n_cmp++;
        if (bus.cpu_full !== (cpu_q.size() == DEPTH)) begin
            n_err++;
            $display("FAIL cpu_full: got %b required %b", bus.cpu_full, (cpu_q.size() == DEPTH));
        end
        if (hold_mode) begin
            bus.uart_busy = hold_level;
        end else begin
            bus.uart_busy = (frame_left > 0);
            if (frame_left > 0) frame_left--;
        end
        bus.ps2_valid = 1'b0;
        bus.cpu_wen   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.ps2_valid = 1'b0;
        bus.ps2_byte  = 8'h00;
        bus.cpu_wen   = 1'b0;
        bus.cpu_byte  = 8'h00;
        bus.uart_busy = 1'b0;
        ps2_q.delete();
        cpu_q.delete();
        launches.delete();
        last_cpu    = 1'b1;
        hold_mode   = 1'b0;
        hold_level  = 1'b0;
        frame_left  = 0;
        drop_pulses = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_launch(input int bound);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.uart_tx_en !== 1'b1 && k < bound);
        n_cmp++;
        if (bus.uart_tx_en !== 1'b1) begin
            n_err++;
            $display("FAIL launch_timeout: no uart_tx_en within %0d cycles", bound);
        end
    endtask

    task automatic drain_to(input int n, input int bound);
        int k;
        k = 0;
        while (launches.size() < n && k < bound) begin
            tick();
            k++;
        end
        n_cmp++;
        if (launches.size() != n) begin
            n_err++;
            $display("FAIL drain_count: got %0d launches required %0d", launches.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 5;
        if (bus.uart_tx_en !== 1'b0)     begin n_err++; $display("FAIL rst_tx_en: got %b required 0", bus.uart_tx_en); end
        if (bus.uart_tx_data !== 8'h00)  begin n_err++; $display("FAIL rst_tx_data: got %h required 00", bus.uart_tx_data); end
        if (bus.ps2_drop !== 1'b0)       begin n_err++; $display("FAIL rst_ps2_drop: got %b required 0", bus.ps2_drop); end
        if (bus.cpu_full !== 1'b0)       begin n_err++; $display("FAIL rst_cpu_full: got %b required 0", bus.cpu_full); end
        if (bus.sched_idle !== 1'b1)     begin n_err++; $display("FAIL rst_idle: got %b required 1", bus.sched_idle); end
        hold_mode = 1'b1;
        hold_level = 1'b1;
        bus.ps2_valid = 1'b1;
        bus.ps2_byte  = 8'hA5;
        wait_launch(5);
        tick();
        tick();
        n_cmp++;
        if (bus.sched_idle !== 1'b0) begin n_err++; $display("FAIL mid_frame_busy: sched_idle got %b required 0", bus.sched_idle); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp += 3;
        if (bus.uart_tx_en !== 1'b0)    begin n_err++; $display("FAIL async_tx_en: got %b required 0", bus.uart_tx_en); end
        if (bus.uart_tx_data !== 8'h00) begin n_err++; $display("FAIL async_tx_data: got %h required 00", bus.uart_tx_data); end
        if (bus.sched_idle !== 1'b1)    begin n_err++; $display("FAIL async_idle: got %b required 1", bus.sched_idle); end
    endtask

    task automatic test_single_byte();
        int k;
        do_reset();
        frame_min = 10;
        frame_max = 10;
        bus.ps2_valid = 1'b1;
        bus.ps2_byte  = 8'h1C;
        tick();
        n_cmp++;
        if (bus.uart_tx_en !== 1'b0) begin n_err++; $display("FAIL latency_early: tx_en got %b required 0", bus.uart_tx_en); end
        tick();
        n_cmp += 2;
        if (bus.uart_tx_en !== 1'b1)    begin n_err++; $display("FAIL latency_2: tx_en got %b required 1", bus.uart_tx_en); end
        if (bus.uart_tx_data !== 8'h1C) begin n_err++; $display("FAIL single_data: got %h required 1C", bus.uart_tx_data); end
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.sched_idle !== 1'b1 && k < 40);
        n_cmp++;
        if (k != 11) begin n_err++; $display("FAIL single_return: idle after %0d cycles required 11", k); end
    endtask

    task automatic test_fairness();
        logic [7:0] a[2];
        logic [7:0] b[2];
        logic [7:0] exp_seq[4];
        do_reset();
        frame_min = 2;
        frame_max = 6;
        for (int i = 0; i < 2; i++) begin
            a[i] = 8'($urandom);
            b[i] = 8'($urandom);
            bus.ps2_valid = 1'b1;
            bus.ps2_byte  = a[i];
            bus.cpu_wen   = 1'b1;
            bus.cpu_byte  = b[i];
            tick();
        end
        exp_seq[0] = a[0];
        exp_seq[1] = b[0];
        exp_seq[2] = a[1];
        exp_seq[3] = b[1];
        drain_to(4, 200);
        for (int i = 0; i < 4 && i < launches.size(); i++) begin
            n_cmp++;
            if (launches[i] !== exp_seq[i]) begin
                n_err++;
                $display("FAIL fair_order[%0d]: got %h required %h", i, launches[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_seq[5];
        do_reset();
        hold_mode  = 1'b1;
        hold_level = 1'b1;
        bus.ps2_valid = 1'b1;
        bus.ps2_byte  = 8'hEE;
        wait_launch(5);
        for (int i = 1; i <= 5; i++) begin
            bus.cpu_wen  = 1'b1;
            bus.cpu_byte = 8'(i);
            tick();
            n_cmp++;
            if (bus.cpu_full !== (i >= 4)) begin
                n_err++;
                $display("FAIL ovf_full_after_%0d: got %b required %b", i, bus.cpu_full, (i >= 4));
            end
        end
`ifdef UART_SCHED_STATS_EN
        n_cmp++;
        if (drop_count !== 16'd1) begin n_err++; $display("FAIL drop_count: got %0d required 1", drop_count); end
`endif
        hold_mode  = 1'b0;
        frame_left = 0;
        frame_min  = 3;
        frame_max  = 8;
        drain_to(5, 300);
        exp_seq[0] = 8'hEE;
        for (int i = 1; i < 5; i++) exp_seq[i] = 8'(i);
        for (int i = 0; i < 5 && i < launches.size(); i++) begin
            n_cmp++;
            if (launches[i] !== exp_seq[i]) begin
                n_err++;
                $display("FAIL ovf_order[%0d]: got %h required %h", i, launches[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        hold_mode  = 1'b1;
        hold_level = 1'b1;
        bus.ps2_valid = 1'b1;
        bus.ps2_byte  = 8'h10;
        wait_launch(5);
        for (int i = 1; i <= 4; i++) begin
            bus.ps2_valid = 1'b1;
            bus.ps2_byte  = 8'(8'h10 + i);
            tick();
        end
        hold_mode   = 1'b0;
        frame_left  = 0;
        drop_pulses = 0;
        tick();
        tick();
        bus.ps2_valid = 1'b1;
        bus.ps2_byte  = 8'h15;
        tick();
        n_cmp += 2;
        if (bus.uart_tx_en !== 1'b1) begin n_err++; $display("FAIL fullpop_same_cycle: tx_en got %b required 1", bus.uart_tx_en); end
        if (bus.ps2_drop !== 1'b1)   begin n_err++; $display("FAIL fullpop_drop: got %b required 1", bus.ps2_drop); end
        drain_to(5, 300);
        repeat (4) tick();
        n_cmp += 2;
        if (drop_pulses != 1) begin n_err++; $display("FAIL fullpop_pulses: got %0d required 1", drop_pulses); end
        if (launches.size() != 5) begin n_err++; $display("FAIL fullpop_total: got %0d launches required 5", launches.size()); end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        hold_mode  = 1'b1;
        hold_level = 1'b0;
        bus.ps2_valid = 1'b1;
        bus.ps2_byte  = 8'h55;
        wait_launch(5);
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.sched_idle !== 1'b1 && k < 60);
        n_cmp++;
        if (k != TIMEOUT + 1) begin n_err++; $display("FAIL timeout_return: idle after %0d cycles required %0d", k, TIMEOUT + 1); end
        bus.cpu_wen  = 1'b1;
        bus.cpu_byte = 8'h66;
        tick();
        tick();
        n_cmp += 2;
        if (bus.uart_tx_en !== 1'b1)    begin n_err++; $display("FAIL timeout_next_en: got %b required 1", bus.uart_tx_en); end
        if (bus.uart_tx_data !== 8'h66) begin n_err++; $display("FAIL timeout_next_data: got %h required 66", bus.uart_tx_data); end
        tick();
`ifdef UART_SCHED_STATS_EN
        n_cmp++;
        if (sent_count !== 16'd2) begin n_err++; $display("FAIL sent_count: got %0d required 2", sent_count); end
`endif
    endtask

    task automatic test_random();
        int k;
        int rate;
        do_reset();
        frame_min = 1;
        frame_max = 8;
        for (int c = 0; c < 1200; c++) begin
            rate = (c < 600) ? 3 : 15;
            bus.ps2_valid = ($urandom_range(rate, 0) == 0);
            bus.ps2_byte  = 8'($urandom);
            bus.cpu_wen   = ($urandom_range(rate, 0) == 0);
            bus.cpu_byte  = 8'($urandom);
            tick();
        end
        k = 0;
        while ((ps2_q.size() != 0 || cpu_q.size() != 0 || bus.sched_idle !== 1'b1) && k < 2000) begin
            tick();
            k++;
        end
        n_cmp += 3;
        if (ps2_q.size() != 0)       begin n_err++; $display("FAIL rand_ps2_left: got %0d queued required 0", ps2_q.size()); end
        if (cpu_q.size() != 0)       begin n_err++; $display("FAIL rand_cpu_left: got %0d queued required 0", cpu_q.size()); end
        if (bus.sched_idle !== 1'b1) begin n_err++; $display("FAIL rand_idle: got %b required 1", bus.sched_idle); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_byte();
        test_fairness();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
